// File: rtl/serial_parity_pkg.sv
// Shared types and constants for the serial even-parity frame checker.
// Optional error counter width is used only when SERIAL_PARITY_ERR_CNT_EN is defined.
package serial_parity_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_e;

    localparam int unsigned ERR_CNT_W = 8;

endpackage

// File: rtl/xor_gate.sv
// Two-input XOR used as the parity accumulator update.
module xor_gate (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = a ^ b;

endmodule

// File: rtl/serial_parity_checker.sv
// Serial frame receiver: start bit (0), DATA_W data bits LSB first, one even-parity bit.
// Define SERIAL_PARITY_ERR_CNT_EN to add a saturating 8-bit parity error counter (err_cnt).
module serial_parity_checker
    import serial_parity_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              frame_valid,
    output logic              parity_err,
`ifdef SERIAL_PARITY_ERR_CNT_EN
    output logic [ERR_CNT_W-1:0] err_cnt,
`endif
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    state_e             state_q, state_d;
    logic               acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               perr_q, perr_d;
    logic               fv_q, fv_d;
    logic               busy_q, busy_d;
    logic               acc_x;

`ifdef SERIAL_PARITY_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
`endif

    xor_gate u_acc_xor (
        .a (acc_q),
        .b (bit_in),
        .y (acc_x)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        perr_d  = perr_q;
        fv_d    = 1'b0;
`ifdef SERIAL_PARITY_ERR_CNT_EN
        err_cnt_d = err_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bit_valid && !bit_in) begin
                    acc_d   = 1'b0;
                    cnt_d   = '0;
                    shift_d = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_valid) begin
                    shift_d[cnt_q] = bit_in;
                    acc_d          = acc_x;
                    // Counter returns to 0 on the last bit so it never exceeds DATA_W-1.
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = PAR;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            PAR: begin
                if (bit_valid) begin
                    perr_d  = acc_x;
                    data_d  = shift_q;
                    fv_d    = 1'b1;
                    state_d = IDLE;
`ifdef SERIAL_PARITY_ERR_CNT_EN
                    if (acc_x && (err_cnt_q != '1)) begin
                        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            perr_q  <= 1'b0;
            fv_q    <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SERIAL_PARITY_ERR_CNT_EN
            err_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            perr_q  <= perr_d;
            fv_q    <= fv_d;
            busy_q  <= busy_d;
`ifdef SERIAL_PARITY_ERR_CNT_EN
            err_cnt_q <= err_cnt_d;
`endif
        end
    end

    assign data_out    = data_q;
    assign parity_err  = perr_q;
    assign frame_valid = fv_q;
    assign busy        = busy_q;
`ifdef SERIAL_PARITY_ERR_CNT_EN
    assign err_cnt     = err_cnt_q;
`endif

endmodule
